lrf_frame_pair_streamer: RTL and testbench

//  Synthesizable AXI4-Stream frame source for the LRF fusion pipeline (feeds CONV_GAUSS and successors).
//  Per job, for each frame f it emits two passes from packed-pixel frame memory: OLD (frame f-lag) then NEW (frame f).

---
 rtl/lrf_frame_pair_streamer_pkg.sv | 26 ++
 rtl/lrf_frame_pair_streamer_if.sv | 16 +
 rtl/lrf_frame_pair_streamer_skid2.sv | 72 +++++++
 rtl/lrf_frame_pair_streamer.sv | 165 ++++++++++++++++
 tb/tb_lrf_frame_pair_streamer.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lrf_frame_pair_streamer_pkg.sv
// Shared constants and helpers for the LRF frame-pair streamer: geometry helpers,
// FSM encoding and tuser bit positions.
package lrf_frame_pair_streamer_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam int unsigned TuserSof   = 0;
  localparam int unsigned TuserPass  = 1;
  localparam int unsigned TuserWidth = 2;

  function automatic int unsigned pixels_per_beat(input int unsigned word_width,
                                                  input int unsigned pixel_width);
    return word_width / pixel_width;
  endfunction

  function automatic int unsigned words_per_image(input int unsigned image_width,
                                                  input int unsigned image_height,
                                                  input int unsigned word_width,
                                                  input int unsigned pixel_width);
    return (image_width * image_height) / pixels_per_beat(word_width, pixel_width);
  endfunction

endpackage

// File: rtl/lrf_frame_pair_streamer_if.sv
// AXI4-Stream master channel carrying pixel words with SOF/pass tuser and tlast.
interface lrf_frame_pair_streamer_if #(
  parameter int unsigned WORD_WIDTH = 128
) ();
  import lrf_frame_pair_streamer_pkg::*;

  logic [WORD_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [TuserWidth-1:0] tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);

endinterface

// File: rtl/lrf_frame_pair_streamer_skid2.sv
// Two-entry registered FIFO between the RAM read port and the stream output; head entry
// drives the outputs straight from flops.
module lrf_frame_pair_streamer_skid2 #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] head_q, head_d;
  logic [Width-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             valid_q, valid_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case ({push_i, pop_i})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d = push_data_i;
        end else begin
          tail_d = push_data_i;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd2) begin
          head_d = tail_q;
        end
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Count unchanged; the older tail entry moves up ahead of the new word.
        if (count_q == 2'd2) begin
          head_d = tail_q;
          tail_d = push_data_i;
        end else begin
          head_d = push_data_i;
        end
      end
      default: ;
    endcase
    valid_d = (count_d != 2'd0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/lrf_frame_pair_streamer.sv
// Frame-pair source: per frame f streams OLD (f-lag) then NEW (f) from packed-pixel RAM
// over AXI4-Stream, credit-limited so no read data is ever lost under backpressure.
module lrf_frame_pair_streamer
  import lrf_frame_pair_streamer_pkg::*;
#(
  parameter int unsigned WORD_WIDTH   = 128,
  parameter int unsigned PIXEL_WIDTH  = 8,
  parameter int unsigned IMAGE_WIDTH  = 512,
  parameter int unsigned IMAGE_HEIGHT = 512,
  parameter int unsigned MAX_FRAMES   = 16,
  parameter int unsigned TLAST_MODE   = 0,
  localparam int unsigned FW = $clog2(MAX_FRAMES + 1),
  localparam int unsigned WordsPerImage =
      words_per_image(IMAGE_WIDTH, IMAGE_HEIGHT, WORD_WIDTH, PIXEL_WIDTH),
  localparam int unsigned MEM_AW = $clog2(MAX_FRAMES * WordsPerImage)
) (
  input  logic                  s_axis_aclk,
  input  logic                  s_axis_aresetn,
  input  logic                  start,
  input  logic [FW-1:0]         n_frames,
  input  logic [7:0]            frame_lag,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_ren,
  output logic [MEM_AW-1:0]     mem_raddr,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  lrf_frame_pair_streamer_if.master m_axis
);

  localparam int unsigned BeatW  = $clog2(WordsPerImage);
  localparam int unsigned FrameW = MEM_AW - BeatW;
  localparam int unsigned CmpW   = ((FW > 8) ? FW : 8) + 1;
  localparam int unsigned SideW  = TuserWidth + 1;
  localparam int unsigned SkidW  = WORD_WIDTH + SideW;

  logic [1:0]       state_q, state_d;
  logic [FW-1:0]    f_q, f_d;
  logic [FW-1:0]    nfr_q, nfr_d;
  logic             pass_q, pass_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic [7:0]       lag_q, lag_d;
  logic             rd_q, rd_d;
  logic [SideW-1:0] rd_side_q, rd_side_d;

  logic                  last_beat, last_job;
  logic                  tlast_req;
  logic [TuserWidth-1:0] tuser_req;
  logic                  lag_ok;
  logic [FrameW-1:0]     old_frame, cur_frame;
  logic                  pop;
  logic [2:0]            credit_use;
  logic [1:0]            skid_count;
  logic                  skid_valid;
  logic [SkidW-1:0]      skid_data;

  assign lag_ok    = CmpW'(f_q) >= CmpW'(lag_q);
  assign old_frame = lag_ok ? (FrameW'(f_q) - FrameW'(lag_q)) : '0;
  assign cur_frame = pass_q ? FrameW'(f_q) : old_frame;
  assign mem_raddr = {cur_frame, beat_q};

  assign last_beat = (beat_q == BeatW'(WordsPerImage - 1));
  assign last_job  = last_beat && pass_q && (f_q == nfr_q - FW'(1));
  assign tlast_req = (TLAST_MODE == 0) ? last_beat : last_job;

  always_comb begin
    tuser_req            = '0;
    tuser_req[TuserSof]  = (beat_q == '0);
    tuser_req[TuserPass] = pass_q;
  end

  // Occupancy the skid will have once this cycle's in-flight read lands and any pop retires.
  assign pop        = skid_valid & m_axis.tready;
  assign credit_use = 3'(skid_count) + 3'(rd_q) - 3'(pop);
  assign mem_ren    = (state_q == StIssue) && (credit_use < 3'd2);

  always_comb begin
    state_d   = state_q;
    f_d       = f_q;
    nfr_d     = nfr_q;
    pass_d    = pass_q;
    beat_d    = beat_q;
    lag_d     = lag_q;
    rd_d      = mem_ren;
    rd_side_d = {tlast_req, tuser_req};
    unique case (state_q)
      StIdle: begin
        if (start) begin
          nfr_d   = (n_frames > FW'(MAX_FRAMES)) ? FW'(MAX_FRAMES) : n_frames;
          lag_d   = frame_lag;
          f_d     = '0;
          pass_d  = 1'b0;
          beat_d  = '0;
          state_d = (n_frames == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        if (mem_ren) begin
          if (last_job) begin
            state_d = StDrain;
          end
          if (last_beat) begin
            beat_d = '0;
            pass_d = ~pass_q;
            if (pass_q) begin
              f_d = f_q + FW'(1);
            end
          end else begin
            beat_d = beat_q + BeatW'(1);
          end
        end
      end
      StDrain: begin
        if ((skid_count == 2'd0) && !rd_q) begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q   <= StIdle;
      f_q       <= '0;
      nfr_q     <= '0;
      pass_q    <= 1'b0;
      beat_q    <= '0;
      lag_q     <= '0;
      rd_q      <= 1'b0;
      rd_side_q <= '0;
    end else begin
      state_q   <= state_d;
      f_q       <= f_d;
      nfr_q     <= nfr_d;
      pass_q    <= pass_d;
      beat_q    <= beat_d;
      lag_q     <= lag_d;
      rd_q      <= rd_d;
      rd_side_q <= rd_side_d;
    end
  end

  lrf_frame_pair_streamer_skid2 #(
    .Width (SkidW)
  ) u_skid (
    .clk_i       (s_axis_aclk),
    .rst_ni      (s_axis_aresetn),
    .push_i      (rd_q),
    .push_data_i ({rd_side_q, mem_rdata}),
    .pop_i       (pop),
    .valid_o     (skid_valid),
    .data_o      (skid_data),
    .count_o     (skid_count)
  );

  assign m_axis.tvalid = skid_valid;
  assign m_axis.tlast  = skid_data[SkidW-1];
  assign m_axis.tuser  = skid_data[WORD_WIDTH +: TuserWidth];
  assign m_axis.tdata  = skid_data[WORD_WIDTH-1:0];

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_lrf_frame_pair_streamer.sv
// Drives two streamers (TLAST_MODE 0 and 1) with shared stimulus and checks each output
// stream against a queue of expected beats built from frame/pass/beat arithmetic.
module tb_lrf_frame_pair_streamer;

  localparam int unsigned WW   = 32;
  localparam int unsigned Wpi  = 8;
  localparam int unsigned MaxF = 16;
  localparam int unsigned Fw   = 5;
  localparam int unsigned Aw   = 7;

  typedef struct packed {
    logic [WW-1:0] data;
    logic [1:0]    user;
    logic          last;
  } beat_t;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b1;
  logic          start     = 1'b0;
  logic          tready    = 1'b0;
  logic          rmode     = 1'b1;
  logic [Fw-1:0] n_frames  = '0;
  logic [7:0]    frame_lag = '0;

  always #5 clk = ~clk;

  logic [1:0]    busy_w, done_w, tvalid_w, tlast_w;
  logic [WW-1:0] tdata_w [2];
  logic [1:0]    tuser_w [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic          ren;
    logic [Aw-1:0] raddr;
    logic [WW-1:0] rdata;

    lrf_frame_pair_streamer_if #(.WORD_WIDTH(WW)) axis ();

    // RAM whose content at each word equals its address, one cycle read latency.
    always @(posedge clk) if (ren) rdata <= WW'(raddr);

    lrf_frame_pair_streamer #(
      .WORD_WIDTH   (WW),
      .PIXEL_WIDTH  (8),
      .IMAGE_WIDTH  (8),
      .IMAGE_HEIGHT (4),
      .MAX_FRAMES   (MaxF),
      .TLAST_MODE   (g)
    ) u_dut (
      .s_axis_aclk    (clk),
      .s_axis_aresetn (rst_n),
      .start          (start),
      .n_frames       (n_frames),
      .frame_lag      (frame_lag),
      .busy           (busy_w[g]),
      .done           (done_w[g]),
      .mem_ren        (ren),
      .mem_raddr      (raddr),
      .mem_rdata      (rdata),
      .m_axis         (axis)
    );

    assign axis.tready = tready;
    assign tvalid_w[g] = axis.tvalid;
    assign tlast_w[g]  = axis.tlast;
    assign tdata_w[g]  = axis.tdata;
    assign tuser_w[g]  = axis.tuser;
  end

  beat_t expq [2][$];
  int    tests = 0;
  int    fails = 0;
  int    done_cnt [2] = '{0, 0};
  int    hs_cnt   [2] = '{0, 0};
  int    age      [2] = '{0, 0};
  int    lat      [2] = '{0, 0};
  bit    active     [2];
  bit    seen_first [2];
  bit    cont       [2];
  bit    stall      [2];
  beat_t held       [2];

  function automatic void chk(input string name, input int inst,
                              input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h at %0t", name, inst, act, exp, $time);
    end
  endfunction

  // Ideal job stream: frames in order, OLD then NEW, RAM word equals its address.
  function automatic void build(input int inst, input int nf, input int lag);
    int nfc;
    nfc = (nf > int'(MaxF)) ? int'(MaxF) : nf;
    expq[inst].delete();
    for (int f = 0; f < nfc; f++) begin
      for (int p = 0; p < 2; p++) begin
        for (int b = 0; b < int'(Wpi); b++) begin
          int    fr;
          beat_t e;
          fr     = (p == 1) ? f : ((f >= lag) ? f - lag : 0);
          e.data = WW'(fr * int'(Wpi) + b);
          e.user = {1'(p), b == 0};
          e.last = (inst == 0) ? (b == int'(Wpi) - 1)
                               : (f == nfc - 1 && p == 1 && b == int'(Wpi) - 1);
          expq[inst].push_back(e);
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      beat_t cur;
      int    nlast;
      cur = {tdata_w[i], tuser_w[i], tlast_w[i]};
      if (!rst_n) begin
        chk("rst_tvalid", i, tvalid_w[i], 0);
        chk("rst_busy", i, busy_w[i], 0);
        chk("rst_done", i, done_w[i], 0);
        chk("rst_outputs", i, cur, 0);
        expq[i].delete();
        active[i] = 0;
        stall[i]  = 0;
      end else begin
        if (start && !active[i]) begin
          build(i, int'(n_frames), int'(frame_lag));
          active[i]     = 1;
          age[i]        = 0;
          lat[i]        = 0;
          seen_first[i] = 0;
          cont[i]       = rmode;
          if (n_frames == 1 && frame_lag == 16) begin
            chk("model_len_1f", i, expq[i].size(), 16);
            chk("model_beat8", i, expq[i][8], {32'd0, 2'b11, 1'b0});
            chk("model_beat7_last", i, expq[i][7].last, (i == 0) ? 1 : 0);
          end
          if (n_frames == 3 && frame_lag == 1) begin
            chk("model_len_3f", i, expq[i].size(), 48);
            chk("model_base16", i, expq[i][16].data, 0);
            chk("model_base24", i, expq[i][24].data, 8);
            chk("model_base40", i, expq[i][40].data, 16);
          end
          if (i == 1 && n_frames == 2) begin
            nlast = 0;
            foreach (expq[i][k]) if (expq[i][k].last) nlast++;
            chk("model_mode1_nlast", i, nlast, 1);
            chk("model_mode1_last31", i, expq[i][31].last, 1);
          end
        end else if (active[i]) begin
          age[i]++;
          lat[i]++;
        end
        if (done_w[i]) begin
          chk("done_while_active", i, active[i], 1);
          chk("done_queue_empty", i, expq[i].size(), 0);
          chk("busy_in_done", i, busy_w[i], 1);
          active[i] = 0;
          done_cnt[i]++;
        end
        if (tvalid_w[i]) begin
          if (expq[i].size() == 0) begin
            chk("extra_beat", i, tvalid_w[i], 0);
          end else begin
            if (!seen_first[i]) begin
              chk("first_latency", i, lat[i], 3);
              seen_first[i] = 1;
            end
            chk("beat", i, cur, expq[i][0]);
            chk("busy_streaming", i, busy_w[i], 1);
            if (stall[i]) chk("stall_stable", i, cur, held[i]);
            if (tready) begin
              void'(expq[i].pop_front());
              hs_cnt[i]++;
              stall[i] = 0;
            end else begin
              stall[i] = 1;
              held[i]  = cur;
            end
          end
        end else begin
          if (stall[i]) chk("tvalid_dropped", i, tvalid_w[i], 1);
          stall[i] = 0;
          if (active[i] && cont[i] && seen_first[i] && expq[i].size() > 0)
            chk("stream_gap", i, tvalid_w[i], 1);
        end
        if (active[i] && age[i] > 4000) begin
          chk("job_timeout", i, age[i], 0);
          active[i] = 0;
          expq[i].delete();
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 tready = rmode ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  task automatic pulse_start(input int nf, input int lag);
    @(posedge clk);
    #1;
    start     = 1'b1;
    n_frames  = Fw'(nf);
    frame_lag = 8'(lag);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_job(input int nf, input int lag, input logic ready_all,
                         input bit poke_busy);
    int d0, d1, c;
    rmode = ready_all;
    d0    = done_cnt[0];
    d1    = done_cnt[1];
    pulse_start(nf, lag);
    if (poke_busy) begin
      repeat (5) @(posedge clk);
      pulse_start(int'($urandom_range(1, 3)), int'($urandom_range(0, 3)));
    end
    c = 0;
    while ((done_cnt[0] == d0 || done_cnt[1] == d1) && c < 5000) begin
      @(posedge clk);
      c++;
    end
  endtask

  initial begin
    int h0, c;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_job(1, 16, 1'b1, 0);
    run_job(3, 1, 1'b1, 0);
    run_job(2, 0, 1'b1, 0);
    run_job(0, 5, 1'b1, 0);
    run_job(20, 2, 1'b1, 0);
    for (int k = 0; k < 6; k++) begin
      run_job(int'($urandom_range(1, 4)), int'($urandom_range(0, 5)), 1'b0, 1);
    end

    // Asynchronous reset in the middle of a job, then a fresh job from address 0.
    rmode = 1'b1;
    h0    = hs_cnt[0];
    pulse_start(2, 0);
    c = 0;
    while (hs_cnt[0] < h0 + 5 && c < 200) begin
      @(posedge clk);
      c++;
    end
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_job(1, 3, 1'b1, 0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
